// File: rtl/data_mem.sv
// data_mem: single-port 2^AW x DW data memory with a request/ready handshake
// and a hardware bulk-clear sequence that zeroes the whole array.
module data_mem #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic [AW-1:0] DataAddress,
  input  logic [DW-1:0] DataIn,
  input  logic          MemWrite,
  input  logic          MemRead,
  input  logic          ClearStart,
  output logic          Ready,
  output logic [DW-1:0] DataOut,
  output logic          DataValid
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] CLR_LAST = {AW{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_next;
  logic [AW-1:0] clr_cnt;
  logic [AW-1:0] clr_next;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          load;

  // Ready depends on state only, so the upstream PC stall has no input path.
  assign Ready = (state == IDLE);

  always_comb begin
    state_next = state;
    addr_next  = addr_q;
    clr_next   = clr_cnt;
    mem_we     = 1'b0;
    mem_waddr  = DataAddress;
    mem_wdata  = DataIn;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (ClearStart) begin
          state_next = CLEAR;
          clr_next   = {AW{1'b0}};
        end else if (MemWrite) begin
          mem_we = 1'b1;
        end else if (MemRead) begin
          state_next = READ;
          addr_next  = DataAddress;
        end else begin
          state_next = IDLE;
        end
      end
      READ: begin
        load       = 1'b1;
        state_next = IDLE;
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt;
        mem_wdata = {DW{1'b0}};
        clr_next  = clr_cnt + AW'(1);
        if (clr_cnt == CLR_LAST) begin
          state_next = IDLE;
        end else begin
          state_next = CLEAR;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      addr_q    <= {AW{1'b0}};
      clr_cnt   <= {AW{1'b0}};
      DataOut   <= {DW{1'b0}};
      DataValid <= 1'b0;
    end else begin
      state     <= state_next;
      addr_q    <= addr_next;
      clr_cnt   <= clr_next;
      DataValid <= load;
      if (load) begin
        DataOut <= mem[addr_q];
      end else begin
        DataOut <= DataOut;
      end
    end
  end

  // Array contents are deliberately left out of reset.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule
